// File: rtl/burst_rr_arbitrator.sv
// rtl/burst_rr_arbitrator.sv - round-robin burst arbiter with in-order tag FIFO for result steering
module burst_rr_arbitrator #(
   parameter int SERV_DATA_WIDTH     = 72,
   parameter int RSLT_DATA_WIDTH     = SERV_DATA_WIDTH,
   parameter int SUPP_DATA_WIDTH     = 19,
   parameter int NUM_CLIENTS         = 4,
   parameter int MAX_BURST           = 4,
   parameter int TAG_FIFO_DEPTH_BITS = 2
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [SUPP_DATA_WIDTH*NUM_CLIENTS-1:0] client_supp_data,
   input  logic [SERV_DATA_WIDTH*NUM_CLIENTS-1:0] client_serv_data,
   input  logic [NUM_CLIENTS-1:0]                 client_req,
   output logic [NUM_CLIENTS-1:0]                 client_ack,
   output logic [NUM_CLIENTS-1:0]                 client_vld,
   output logic [RSLT_DATA_WIDTH-1:0]             client_rslt_data,
   output logic [SUPP_DATA_WIDTH-1:0]             server_supp_data,
   output logic [SERV_DATA_WIDTH-1:0]             server_serv_data,
   output logic                                   server_req,
   input  logic                                   server_ack,
   input  logic                                   server_vld,
   input  logic [RSLT_DATA_WIDTH-1:0]             server_rslt_data,
   output logic [TAG_FIFO_DEPTH_BITS:0]           num_outstanding,
   output logic                                   rslt_err
);
   localparam int CW    = $clog2(NUM_CLIENTS);
   localparam int DEPTH = 1 << TAG_FIFO_DEPTH_BITS;
   localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0]                     state;
   logic [CW-1:0]                  sel;
   logic [CW-1:0]                  last_grant;
   logic [CW-1:0]                  pick;
   logic                           pick_vld;
   logic [7:0]                     burst_cnt;
   logic [CW-1:0]                  tag_mem [DEPTH];
   logic [TAG_FIFO_DEPTH_BITS-1:0] wr_ptr;
   logic [TAG_FIFO_DEPTH_BITS-1:0] rd_ptr;
   logic [TAG_FIFO_DEPTH_BITS:0]   count;
   logic                           granting;
   logic                           fifo_full;
   logic                           fifo_empty;
   logic                           accept;
   logic                           pop;

   assign granting   = (state == ST_GRANT);
   assign fifo_full  = (count == (TAG_FIFO_DEPTH_BITS+1)'(DEPTH));
   assign fifo_empty = (count == '0);
   assign server_req = granting & client_req[sel] & ~fifo_full;
   assign accept     = server_req & server_ack;
   assign pop        = server_vld & ~fifo_empty;

   assign client_ack       = accept ? (NUM_CLIENTS'(1) << sel) : '0;
   assign client_vld       = pop ? (NUM_CLIENTS'(1) << tag_mem[rd_ptr]) : '0;
   assign client_rslt_data = server_rslt_data;
   assign server_supp_data = granting ? client_supp_data[sel*SUPP_DATA_WIDTH +: SUPP_DATA_WIDTH] : '0;
   assign server_serv_data = granting ? client_serv_data[sel*SERV_DATA_WIDTH +: SERV_DATA_WIDTH] : '0;
   assign num_outstanding  = count;

   // Scan from farthest to nearest offset so the nearest requester after last_grant wins.
   always_comb begin
      logic [CW-1:0] idx;
      pick     = last_grant;
      pick_vld = 1'b0;
      idx      = '0;
      for (int i = NUM_CLIENTS; i >= 1; i--) begin
         idx = last_grant + CW'(i);
         if (client_req[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         sel        <= '0;
         last_grant <= CW'(NUM_CLIENTS - 1);
         burst_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  sel       <= pick;
                  burst_cnt <= '0;
                  state     <= ST_GRANT;
               end
            end
            default: begin
               if (accept) begin
                  if (burst_cnt == LAST_BEAT) begin
                     state      <= ST_IDLE;
                     last_grant <= sel;
                  end else begin
                     burst_cnt <= burst_cnt + 8'd1;
                  end
               end else if (!client_req[sel]) begin
                  state      <= ST_IDLE;
                  last_grant <= sel;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) tag_mem[wr_ptr] <= sel;
   end

   // A result with nothing outstanding is dropped, never matched to a same-cycle push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rslt_err <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (server_vld && fifo_empty) rslt_err <= 1'b1;
      end
   end
endmodule
